// File: rtl/inst_buffer.sv
// Instruction buffer between fetch and decode.
// Circular FIFO: up to two entries in per cycle, the two oldest presented to
// decode, up to two retired per cycle. A redirect (flush) empties it.
module inst_buffer #(
  parameter int DEPTH  = 16,
  parameter int EXCP_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [1:0]        i_size,
  input  logic [31:0]       i_pc0,
  input  logic [31:0]       i_inst0,
  input  logic              i_pred_taken0,
  input  logic [31:0]       i_pred_target0,
  input  logic [31:0]       i_pc1,
  input  logic [31:0]       i_inst1,
  input  logic              i_pred_taken1,
  input  logic [31:0]       i_pred_target1,
  input  logic              i_excp,
  input  logic [EXCP_W-1:0] i_excp_type,
  output logic              i_ready,
  output logic              o_valid0,
  output logic              o_valid1,
  output logic [31:0]       o_pc0,
  output logic [31:0]       o_pc1,
  output logic [31:0]       o_inst0,
  output logic [31:0]       o_inst1,
  output logic              o_pred_taken0,
  output logic              o_pred_taken1,
  output logic [31:0]       o_pred_target0,
  output logic [31:0]       o_pred_target1,
  output logic              o_excp0,
  output logic              o_excp1,
  output logic [EXCP_W-1:0] o_excp_type0,
  output logic [EXCP_W-1:0] o_excp_type1,
  input  logic [1:0]        o_pop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       inst;
    logic              pred_taken;
    logic [31:0]       pred_target;
    logic              excp;
    logic [EXCP_W-1:0] excp_type;
  } entry_t;

  entry_t mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [CNT_W-1:0] space, size_req, push_cnt, pop_req, pop_eff;
  logic             wr_en [2];
  entry_t           wr_entry [2];
  logic [1:0]       slot_valid;
  entry_t           slot_entry [2];

  // Clamp push/pop amounts so unread entries are never overwritten and
  // reads never run past the oldest valid entry; flush overrides everything.
  always_comb begin
    size_req    = i_size[1] ? CNT_W'(2) : CNT_W'(i_size[0]);
    pop_req     = o_pop[1]  ? CNT_W'(2) : CNT_W'(o_pop[0]);
    space       = CNT_W'(DEPTH) - count_reg;
    push_cnt    = (size_req > space) ? space : size_req;
    pop_eff     = (pop_req > count_reg) ? count_reg : pop_req;
    wr_en[0]    = !flush && (push_cnt >= CNT_W'(1));
    wr_en[1]    = !flush && (push_cnt >= CNT_W'(2));
    wr_entry[0] = '{pc: i_pc0, inst: i_inst0, pred_taken: i_pred_taken0,
                    pred_target: i_pred_target0, excp: i_excp,
                    excp_type: i_excp_type};
    // Fetch exceptions only ever tag the first slot of a fetch group.
    wr_entry[1] = '{pc: i_pc1, inst: i_inst1, pred_taken: i_pred_taken1,
                    pred_target: i_pred_target1, excp: 1'b0,
                    excp_type: '0};
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      rd_ptr_next = rd_ptr_reg + pop_eff[PTR_W-1:0];
      wr_ptr_next = wr_ptr_reg + push_cnt[PTR_W-1:0];
      count_next  = count_reg + push_cnt - pop_eff;
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Entry storage writes; slot 1 lands at the next (wrapping) address.
  always_ff @(posedge clk) begin
    if (wr_en[0]) mem[wr_ptr_reg] <= wr_entry[0];
    if (wr_en[1]) mem[wr_ptr_reg + PTR_W'(1)] <= wr_entry[1];
  end

  // Two read ports at rd_ptr and rd_ptr+1, wrapping naturally at DEPTH.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [PTR_W-1:0] rd_addr;
    assign rd_addr         = rd_ptr_reg + PTR_W'(gi);
    assign slot_valid[gi]  = (count_reg > CNT_W'(gi));
    assign slot_entry[gi]  = mem[rd_addr];
  end

  assign o_valid0       = slot_valid[0];
  assign o_valid1       = slot_valid[1];
  assign o_pc0          = slot_entry[0].pc;
  assign o_pc1          = slot_entry[1].pc;
  assign o_inst0        = slot_entry[0].inst;
  assign o_inst1        = slot_entry[1].inst;
  assign o_pred_taken0  = slot_entry[0].pred_taken;
  assign o_pred_taken1  = slot_entry[1].pred_taken;
  assign o_pred_target0 = slot_entry[0].pred_target;
  assign o_pred_target1 = slot_entry[1].pred_target;
  // Stale storage must never look like an exception to decode.
  assign o_excp0        = slot_valid[0] & slot_entry[0].excp;
  assign o_excp1        = slot_valid[1] & slot_entry[1].excp;
  assign o_excp_type0   = slot_entry[0].excp_type;
  assign o_excp_type1   = slot_entry[1].excp_type;

  // Room for the data arriving now plus one newly issued request.
  assign i_ready = !reset && (space >= CNT_W'(4));

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer: scoreboard queue of expected entries
// plus per-scenario inline checks.
module tb_inst_buffer;

  localparam int         DEPTH = 16;
  localparam logic [5:0] TLBR  = 6'h3f;

  logic        clk, reset, flush;
  logic [1:0]  i_size, o_pop;
  logic [31:0] i_pc0, i_inst0, i_pred_target0, i_pc1, i_inst1, i_pred_target1;
  logic        i_pred_taken0, i_pred_taken1, i_excp;
  logic [5:0]  i_excp_type;
  logic        i_ready, o_valid0, o_valid1;
  logic [31:0] o_pc0, o_pc1, o_inst0, o_inst1, o_pred_target0, o_pred_target1;
  logic        o_pred_taken0, o_pred_taken1, o_excp0, o_excp1;
  logic [5:0]  o_excp_type0, o_excp_type1;

  inst_buffer #(.DEPTH(DEPTH), .EXCP_W(6)) dut (
    .clk(clk), .reset(reset), .flush(flush), .i_size(i_size),
    .i_pc0(i_pc0), .i_inst0(i_inst0), .i_pred_taken0(i_pred_taken0),
    .i_pred_target0(i_pred_target0),
    .i_pc1(i_pc1), .i_inst1(i_inst1), .i_pred_taken1(i_pred_taken1),
    .i_pred_target1(i_pred_target1),
    .i_excp(i_excp), .i_excp_type(i_excp_type), .i_ready(i_ready),
    .o_valid0(o_valid0), .o_valid1(o_valid1), .o_pc0(o_pc0), .o_pc1(o_pc1),
    .o_inst0(o_inst0), .o_inst1(o_inst1),
    .o_pred_taken0(o_pred_taken0), .o_pred_taken1(o_pred_taken1),
    .o_pred_target0(o_pred_target0), .o_pred_target1(o_pred_target1),
    .o_excp0(o_excp0), .o_excp1(o_excp1),
    .o_excp_type0(o_excp_type0), .o_excp_type1(o_excp_type1),
    .o_pop(o_pop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pt;
    logic [31:0] tgt;
    logic        ex;
    logic [5:0]  et;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  bit          mon_en   = 1'b0;
  logic [31:0] next_pc  = 32'h1c000000;

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] inst,
                              input logic ex, input logic [5:0] et);
    exp_t e;
    e.pc   = pc;
    e.inst = inst;
    e.pt   = pc[3];
    e.tgt  = pc + 32'h100;
    e.ex   = ex;
    e.et   = et;
    return e;
  endfunction

  // Drive one cycle of stimulus, then update the scoreboard to the state the
  // DUT should hold after the clock edge.
  task automatic drive(input logic [1:0] size, input logic [31:0] pc0,
                       input logic [31:0] inst0, input logic [31:0] pc1,
                       input logic ex, input logic [5:0] et,
                       input logic [1:0] pop, input logic fl);
    exp_t e0, e1;
    e0 = mk(pc0, inst0, ex, et);
    e1 = mk(pc1, ~pc1, 1'b0, 6'd0);
    if (int'(pop) > sb.size()) begin
      failures++;
      $display("FAIL illegal_pop: o_pop=%0d exceeds count=%0d", pop, sb.size());
    end
    if (!fl && int'(size) + sb.size() > DEPTH) begin
      failures++;
      $display("FAIL overflow_push: size=%0d count=%0d", size, sb.size());
    end
    i_size = size; o_pop = pop; flush = fl;
    i_pc0 = e0.pc; i_inst0 = e0.inst; i_pred_taken0 = e0.pt; i_pred_target0 = e0.tgt;
    i_pc1 = e1.pc; i_inst1 = e1.inst; i_pred_taken1 = e1.pt; i_pred_target1 = e1.tgt;
    i_excp = ex; i_excp_type = et;
    @(posedge clk);
    #1;
    if (fl) begin
      sb.delete();
    end else begin
      for (int k = 0; k < int'(pop) && sb.size() > 0; k++) void'(sb.pop_front());
      if (size >= 2'd1) sb.push_back(e0);
      if (size == 2'd2) sb.push_back(e1);
    end
    i_size = 2'd0; o_pop = 2'd0; flush = 1'b0; i_excp = 1'b0;
  endtask

  task automatic push_seq(input logic [1:0] size, input logic [1:0] pop);
    drive(size, next_pc, ~next_pc, next_pc + 32'd4, 1'b0, 6'd0, pop, 1'b0);
    next_pc = next_pc + 32'd4 * 32'(size);
  endtask

  // Scoreboard monitor: compare both output slots against the expected queue.
  always @(negedge clk) begin : mon
    int   n;
    logic ev0, ev1, er;
    if (mon_en) begin
      n   = sb.size();
      ev0 = (n >= 1);
      ev1 = (n >= 2);
      er  = ((DEPTH - n) >= 4);
      checks++;
      if (o_valid0 !== ev0) begin failures++; $display("FAIL sb_valid0: got %b exp %b", o_valid0, ev0); end
      checks++;
      if (o_valid1 !== ev1) begin failures++; $display("FAIL sb_valid1: got %b exp %b", o_valid1, ev1); end
      checks++;
      if (i_ready !== er) begin failures++; $display("FAIL sb_ready: got %b exp %b (count %0d)", i_ready, er, n); end
      if (n >= 1) begin
        checks++;
        if (o_pc0 !== sb[0].pc || o_inst0 !== sb[0].inst || o_pred_taken0 !== sb[0].pt ||
            o_pred_target0 !== sb[0].tgt || o_excp0 !== sb[0].ex ||
            (sb[0].ex && o_excp_type0 !== sb[0].et)) begin
          failures++;
          $display("FAIL sb_slot0: got pc=%h inst=%h pt=%b tgt=%h ex=%b et=%h exp pc=%h inst=%h pt=%b tgt=%h ex=%b et=%h",
                   o_pc0, o_inst0, o_pred_taken0, o_pred_target0, o_excp0, o_excp_type0,
                   sb[0].pc, sb[0].inst, sb[0].pt, sb[0].tgt, sb[0].ex, sb[0].et);
        end
      end else begin
        checks++;
        if (o_excp0 !== 1'b0) begin failures++; $display("FAIL sb_excp0_invalid: got %b exp 0", o_excp0); end
      end
      if (n >= 2) begin
        checks++;
        if (o_pc1 !== sb[1].pc || o_inst1 !== sb[1].inst || o_pred_taken1 !== sb[1].pt ||
            o_pred_target1 !== sb[1].tgt || o_excp1 !== sb[1].ex ||
            (sb[1].ex && o_excp_type1 !== sb[1].et)) begin
          failures++;
          $display("FAIL sb_slot1: got pc=%h inst=%h pt=%b tgt=%h ex=%b exp pc=%h inst=%h pt=%b tgt=%h ex=%b",
                   o_pc1, o_inst1, o_pred_taken1, o_pred_target1, o_excp1,
                   sb[1].pc, sb[1].inst, sb[1].pt, sb[1].tgt, sb[1].ex);
        end
      end else begin
        checks++;
        if (o_excp1 !== 1'b0) begin failures++; $display("FAIL sb_excp1_invalid: got %b exp 0", o_excp1); end
      end
    end
  end

  task automatic test_reset();
    mon_en = 1'b0;
    reset = 1'b1; flush = 1'b0; i_size = 2'd0; o_pop = 2'd0; i_excp = 1'b0;
    i_excp_type = 6'd0;
    i_pc0 = '0; i_inst0 = '0; i_pred_taken0 = 1'b0; i_pred_target0 = '0;
    i_pc1 = '0; i_inst1 = '0; i_pred_taken1 = 1'b0; i_pred_target1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (i_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b exp 0", i_ready); end
    checks++;
    if (o_valid0 !== 1'b0 || o_valid1 !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b%b exp 00", o_valid0, o_valid1); end
    checks++;
    if (o_excp0 !== 1'b0 || o_excp1 !== 1'b0) begin failures++; $display("FAIL reset_excp: got %b%b exp 00", o_excp0, o_excp1); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    checks++;
    if (i_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready: got %b exp 1", i_ready); end
    checks++;
    if (o_valid0 !== 1'b0) begin failures++; $display("FAIL post_reset_valid0: got %b exp 0", o_valid0); end
    mon_en = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_push_two();
    push_seq(2'd2, 2'd0);
    @(negedge clk);
    checks++;
    if (o_valid0 !== 1'b1 || o_valid1 !== 1'b1) begin failures++; $display("FAIL push2_valid: got %b%b exp 11", o_valid0, o_valid1); end
    checks++;
    if (o_pc0 !== 32'h1c000000) begin failures++; $display("FAIL push2_pc0: got %h exp 1c000000", o_pc0); end
    checks++;
    if (o_pc1 !== 32'h1c000004) begin failures++; $display("FAIL push2_pc1: got %h exp 1c000004", o_pc1); end
    checks++;
    if (i_ready !== 1'b1) begin failures++; $display("FAIL push2_ready: got %b exp 1", i_ready); end
    push_seq(2'd0, 2'd2);
    $display("test_push_two done");
  endtask

  task automatic test_fill();
    push_seq(2'd1, 2'd0);
    for (int k = 0; k < 6; k++) push_seq(2'd2, 2'd0);
    @(negedge clk);
    checks++;
    if (i_ready !== 1'b0) begin failures++; $display("FAIL fill13_ready: got %b exp 0", i_ready); end
    push_seq(2'd2, 2'd0);
    @(negedge clk);
    checks++;
    if (i_ready !== 1'b0 || sb.size() != 15) begin failures++; $display("FAIL fill15_ready: got %b exp 0", i_ready); end
    push_seq(2'd0, 2'd2);
    @(negedge clk);
    checks++;
    if (i_ready !== 1'b0) begin failures++; $display("FAIL pop_to13_ready: got %b exp 0", i_ready); end
    push_seq(2'd0, 2'd1);
    @(negedge clk);
    checks++;
    if (i_ready !== 1'b1) begin failures++; $display("FAIL pop_to12_ready: got %b exp 1", i_ready); end
    for (int k = 0; k < 6; k++) push_seq(2'd0, 2'd2);
    @(negedge clk);
    checks++;
    if (o_valid0 !== 1'b0) begin failures++; $display("FAIL drained_valid0: got %b exp 0", o_valid0); end
    $display("test_fill done");
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    exp_pc = next_pc;
    for (int k = 0; k < 10; k++) begin
      push_seq(2'd2, 2'd0);
      @(negedge clk);
      checks++;
      if (o_pc0 !== exp_pc || o_pc1 !== exp_pc + 32'd4) begin
        failures++;
        $display("FAIL wrap_pc iter %0d: got %h/%h exp %h/%h", k, o_pc0, o_pc1, exp_pc, exp_pc + 32'd4);
      end
      push_seq(2'd0, 2'd2);
      exp_pc = exp_pc + 32'd8;
    end
    $display("test_wrap done");
  endtask

  task automatic test_exception();
    drive(2'd1, 32'h1c000080, 32'h03400000, 32'h0, 1'b1, TLBR, 2'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (o_excp0 !== 1'b1) begin failures++; $display("FAIL excp_bit: got %b exp 1", o_excp0); end
    checks++;
    if (o_excp_type0 !== TLBR) begin failures++; $display("FAIL excp_type: got %h exp %h", o_excp_type0, TLBR); end
    checks++;
    if (o_valid1 !== 1'b0 || o_inst0 !== 32'h03400000) begin failures++; $display("FAIL excp_slot: got valid1=%b inst0=%h exp 0/03400000", o_valid1, o_inst0); end
    drive(2'd1, 32'h1c000084, 32'h02800000, 32'h0, 1'b0, 6'd0, 2'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (o_excp1 !== 1'b0 || o_excp0 !== 1'b1) begin failures++; $display("FAIL excp_second: got %b%b exp 10", o_excp0, o_excp1); end
    push_seq(2'd0, 2'd2);
    $display("test_exception done");
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) push_seq(2'd2, 2'd0);
    drive(2'd2, 32'h1c0000f0, 32'h0, 32'h1c0000f4, 1'b0, 6'd0, 2'd0, 1'b1);
    @(negedge clk);
    checks++;
    if (o_valid0 !== 1'b0 || o_valid1 !== 1'b0) begin failures++; $display("FAIL flush_valid: got %b%b exp 00", o_valid0, o_valid1); end
    checks++;
    if (i_ready !== 1'b1) begin failures++; $display("FAIL flush_ready: got %b exp 1", i_ready); end
    drive(2'd1, 32'h1c000100, 32'h00000001, 32'h0, 1'b0, 6'd0, 2'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (o_pc0 !== 32'h1c000100 || o_valid1 !== 1'b0) begin failures++; $display("FAIL flush_repush: got pc0=%h valid1=%b exp 1c000100/0", o_pc0, o_valid1); end
    push_seq(2'd0, 2'd1);
    $display("test_flush done");
  endtask

  task automatic test_concurrent();
    push_seq(2'd2, 2'd0);
    drive(2'd1, 32'h1c000200, 32'h12345678, 32'h0, 1'b0, 6'd0, 2'd2, 1'b0);
    @(negedge clk);
    checks++;
    if (o_valid0 !== 1'b1 || o_valid1 !== 1'b0) begin failures++; $display("FAIL conc_valid: got %b%b exp 10", o_valid0, o_valid1); end
    checks++;
    if (o_pc0 !== 32'h1c000200 || o_inst0 !== 32'h12345678) begin failures++; $display("FAIL conc_entry: got %h/%h exp 1c000200/12345678", o_pc0, o_inst0); end
    push_seq(2'd0, 2'd1);
    $display("test_concurrent done");
  endtask

  initial begin
    test_reset();
    test_push_two();
    test_fill();
    test_wrap();
    test_exception();
    test_flush();
    test_concurrent();
    repeat (2) @(posedge clk);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
